// File: rtl/gray_counter_if.sv
// Control/status bundle for gray_counter: step/mode controls in, Gray code and strobes out.
interface gray_counter_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             en;
  logic             up;
  logic             oneshot;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] g;
  logic             running;
  logic             tc;
  logic             done;

  modport master (
    output start, stop, en, up, oneshot, load, load_bin,
    input  g, running, tc, done
  );

  modport slave (
    input  start, stop, en, up, oneshot, load, load_bin,
    output g, running, tc, done
  );
endinterface

// File: rtl/gray_counter.sv
// Registered up/down Gray-code counter with load, wrap/one-shot modes and tc/done strobes.
// Latency: one edge from en to new code; no backpressure, en simply qualifies each step.
module gray_counter #(
  parameter int WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  gray_counter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_g;
  logic             r_os;
  logic             r_running;
  logic             r_tc;
  logic             r_done;

  logic [WIDTH-1:0] w_bin_inc;
  logic [WIDTH-1:0] w_bin_dec;
  logic [WIDTH-1:0] w_start_val;
  logic             w_at_end;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Wrap falls out of modular add/sub, so the wrap step reuses the same paths.
  assign w_bin_inc   = r_bin + ONE;
  assign w_bin_dec   = r_bin - ONE;
  assign w_at_end    = bus.up ? (r_bin == MAX) : (r_bin == '0);
  assign w_start_val = bus.up ? '0 : MAX;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bin     <= '0;
      r_g       <= '0;
      r_os      <= 1'b0;
      r_running <= 1'b0;
      r_tc      <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_tc   <= 1'b0;
      r_done <= 1'b0;
      if (bus.load) begin
        r_bin <= bus.load_bin;
        r_g   <= to_gray(bus.load_bin);
      end else if (bus.stop) begin
        if (r_state != S_IDLE) begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
        end
      end else if (bus.start && r_state != S_RUN) begin
        r_state   <= S_RUN;
        r_os      <= bus.oneshot;
        r_running <= 1'b1;
        // Restarting after a one-shot run begins again from the start of range.
        if (r_state == S_HALT) begin
          r_bin <= w_start_val;
          r_g   <= to_gray(w_start_val);
        end
      end else if (r_state == S_RUN && bus.en) begin
        if (w_at_end && r_os) begin
          r_state   <= S_HALT;
          r_running <= 1'b0;
          r_done    <= 1'b1;
        end else begin
          r_tc  <= w_at_end;
          r_bin <= bus.up ? w_bin_inc : w_bin_dec;
          r_g   <= to_gray(bus.up ? w_bin_inc : w_bin_dec);
        end
      end
    end
  end

  assign bus.g       = r_g;
  assign bus.running = r_running;
  assign bus.tc      = r_tc;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_gray_counter.sv
// Directed-vector bench for gray_counter (WIDTH=4) with hand-computed Gray codes and strobes.
module tb_gray_counter;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [3:0] gtab [16];
  logic [3:0] prev_g;

  gray_counter_if #(.WIDTH(4)) bus();

  gray_counter #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int g, input int run, input int tc, input int done);
    chk({tag, ".g"},       int'(bus.g),       g);
    chk({tag, ".running"}, int'(bus.running), run);
    chk({tag, ".tc"},      int'(bus.tc),      tc);
    chk({tag, ".done"},    int'(bus.done),    done);
  endtask

  // Inputs change 1 time unit after the edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    bus.start = 0; bus.stop = 0; bus.en = 0; bus.up = 1;
    bus.oneshot = 0; bus.load = 0; bus.load_bin = 4'd0;
    rst = 1;
    tick();
    chk_out("reset", 0, 0, 0, 0);
    rst = 0;

    // Start with en high: state change only, no step on this edge.
    bus.start = 1; bus.oneshot = 0; bus.up = 1; bus.en = 1;
    tick();
    chk_out("start_up", 0, 1, 0, 0);
    bus.start = 0;

    prev_g = bus.g;
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk("up_seq.g",  int'(bus.g),  int'(gtab[i % 16]));
      chk("up_seq.tc", int'(bus.tc), int'(i == 16));
      chk("up_seq.hamming", $countones(bus.g ^ prev_g), 1);
      prev_g = bus.g;
    end

    // Load wins over the step in the same cycle; B=5 -> g=0111, then step to 6.
    bus.load = 1; bus.load_bin = 4'b0101;
    tick();
    chk_out("load", 4'b0111, 1, 0, 0);
    bus.load = 0;
    tick();
    chk_out("after_load", 4'b0101, 1, 0, 0);

    bus.stop = 1;
    tick();
    chk_out("stop", 4'b0101, 0, 0, 0);
    bus.stop = 0;

    // One-shot countdown from 2.
    bus.load = 1; bus.load_bin = 4'b0010;
    tick();
    chk_out("os_load", 4'b0011, 0, 0, 0);
    bus.load = 0;
    bus.start = 1; bus.oneshot = 1; bus.up = 0; bus.en = 1;
    tick();
    chk_out("os_start", 4'b0011, 1, 0, 0);
    bus.start = 0;
    tick();
    chk_out("os_b1", 4'b0001, 1, 0, 0);
    tick();
    chk_out("os_b0", 4'b0000, 1, 0, 0);
    tick();
    chk_out("os_halt", 4'b0000, 0, 0, 1);
    tick();
    chk_out("os_hold1", 4'b0000, 0, 0, 0);
    tick();
    chk_out("os_hold2", 4'b0000, 0, 0, 0);
    bus.start = 1;
    tick();
    chk_out("os_restart", 4'b1000, 1, 0, 0);
    bus.start = 0;

    // en pattern 1,0,0,1 from B=3.
    bus.load = 1; bus.load_bin = 4'd3; bus.en = 0;
    tick();
    chk_out("en_load3", 4'b0010, 1, 0, 0);
    bus.load = 0; bus.up = 1; bus.en = 1;
    tick();
    chk_out("en_1", 4'b0110, 1, 0, 0);
    bus.en = 0;
    tick();
    chk_out("en_0a", 4'b0110, 1, 0, 0);
    tick();
    chk_out("en_0b", 4'b0110, 1, 0, 0);
    bus.en = 1;
    tick();
    chk_out("en_1b", 4'b0111, 1, 0, 0);

    // Reverse direction at B=7.
    tick();
    chk_out("rev_b6", 4'b0101, 1, 0, 0);
    tick();
    chk_out("rev_b7", 4'b0100, 1, 0, 0);
    bus.up = 0;
    tick();
    chk_out("rev_dn6", 4'b0101, 1, 0, 0);
    tick();
    chk_out("rev_dn5", 4'b0111, 1, 0, 0);

    // Reset beats load and start at B=12.
    bus.load = 1; bus.load_bin = 4'd12; bus.en = 0;
    tick();
    chk_out("rst_pre", 4'b1010, 1, 0, 0);
    rst = 1; bus.start = 1;
    tick();
    chk_out("rst_mid", 0, 0, 0, 0);
    rst = 0; bus.load = 0; bus.start = 0;

    // Down-mode wrap 0 -> MAX pulses tc.
    bus.start = 1; bus.oneshot = 0; bus.up = 0; bus.en = 1;
    tick();
    chk_out("dn_start", 0, 1, 0, 0);
    bus.start = 0;
    tick();
    chk_out("dn_wrap", 4'b1000, 1, 1, 0);
    tick();
    chk_out("dn_after", 4'b1001, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
